// File: rtl/spi_regfile_target.sv
// SPI mode-0 target that bridges an external controller onto a BRAM-style regfile port.
// Define SPI_TARGET_AUTO_INC_EN to let one frame carry a burst of words at incrementing addresses.
module spi_regfile_target #(
   parameter int Naddr       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             axi_aclk,
   input  logic             axi_aresetn,
   input  logic             spi_sck,
   input  logic             spi_csn,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic             spi_miso_t,
   output logic [Naddr-1:0] regfile_addr,
   output logic [31:0]      regfile_din,
   input  logic [31:0]      regfile_dout,
   output logic             regfile_en,
   output logic [3:0]       regfile_we,
   output logic             busy,
   output logic             frame_err
);

   typedef enum logic [2:0] {IDLE, CMD, RD_FETCH, RD_LOAD, RD_DATA, WR_DATA, DONE} state_t;

   logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
   logic                   sck_prev_q, csn_prev_q;
   logic                   sck_s, csn_s, mosi_s;
   logic                   sck_rise, sck_fall, csn_rise, csn_fall;

   state_t           state_q;
   logic [4:0]       cnt_q;
   logic [31:0]      shift_q;
   logic             word_seen_q;
   logic             miso_q, en_q, busy_q, err_q;
   logic [3:0]       we_q;
   logic [Naddr-1:0] addr_q;
   logic [31:0]      din_q;
   logic [31:0]      word_w;
   logic             err_w;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         sck_sync_q  <= '0;
         csn_sync_q  <= '1;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         csn_prev_q  <= 1'b1;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
         csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         sck_prev_q  <= sck_s;
         csn_prev_q  <= csn_s;
      end
   end

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign csn_s    = csn_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign csn_rise = csn_s & ~csn_prev_q;
   assign csn_fall = ~csn_s & csn_prev_q;
   assign word_w   = {shift_q[30:0], mosi_s};

   // A frame may only end cleanly before the first SCK edge or on a completed word.
   always_comb begin
      err_w = 1'b0;
      case (state_q)
         CMD:               err_w = (cnt_q != 5'd0);
         RD_FETCH, RD_LOAD: err_w = !word_seen_q;
         RD_DATA, WR_DATA:  err_w = !(word_seen_q && cnt_q == 5'd0);
         default:           err_w = 1'b0;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         word_seen_q <= 1'b0;
         miso_q      <= 1'b0;
         en_q        <= 1'b0;
         we_q        <= '0;
         addr_q      <= '0;
         din_q       <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         en_q  <= 1'b0;
         we_q  <= '0;
         err_q <= 1'b0;
`ifdef SPI_TARGET_AUTO_INC_EN
         if (en_q && we_q != 4'h0)
            addr_q <= addr_q + Naddr'(1);
`endif
         if (csn_rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
            err_q   <= err_w;
            cnt_q   <= '0;
         end else if (csn_fall) begin
            state_q     <= CMD;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            miso_q      <= 1'b0;
            word_seen_q <= 1'b0;
         end else begin
            case (state_q)
               CMD: if (sck_rise) begin
                  shift_q <= word_w;
                  if (cnt_q == 5'd7) begin
                     addr_q <= {shift_q[Naddr-2:0], mosi_s};
                     cnt_q  <= '0;
                     if (shift_q[6]) begin
                        en_q    <= 1'b1;
                        state_q <= RD_FETCH;
                     end else begin
                        state_q <= WR_DATA;
                     end
                  end else begin
                     cnt_q <= cnt_q + 5'd1;
                  end
               end
               RD_FETCH: state_q <= RD_LOAD;
               RD_LOAD: begin
                  shift_q <= regfile_dout;
                  state_q <= RD_DATA;
               end
               RD_DATA: begin
                  if (sck_fall) begin
                     miso_q  <= shift_q[31];
                     shift_q <= {shift_q[30:0], 1'b0};
                  end
                  // The word is complete on the rise that samples its last bit.
                  if (sck_rise) begin
                     if (cnt_q == 5'd31) begin
                        cnt_q <= '0;
`ifdef SPI_TARGET_AUTO_INC_EN
                        addr_q      <= addr_q + Naddr'(1);
                        en_q        <= 1'b1;
                        word_seen_q <= 1'b1;
                        state_q     <= RD_FETCH;
`else
                        state_q <= DONE;
`endif
                     end else begin
                        cnt_q <= cnt_q + 5'd1;
                     end
                  end
               end
               WR_DATA: if (sck_rise) begin
                  shift_q <= word_w;
                  if (cnt_q == 5'd31) begin
                     cnt_q <= '0;
                     din_q <= word_w;
                     we_q  <= 4'hf;
                     en_q  <= 1'b1;
`ifdef SPI_TARGET_AUTO_INC_EN
                     word_seen_q <= 1'b1;
`else
                     state_q <= DONE;
                     miso_q  <= 1'b0;
`endif
                  end else begin
                     cnt_q <= cnt_q + 5'd1;
                  end
               end
               DONE: if (sck_fall) miso_q <= 1'b0;
               default: ;
            endcase
         end
      end
   end

   assign spi_miso     = miso_q;
   assign spi_miso_t   = csn_s;
   assign regfile_addr = addr_q;
   assign regfile_din  = din_q;
   assign regfile_en   = en_q;
   assign regfile_we   = we_q;
   assign busy         = busy_q;
   assign frame_err    = err_q;

endmodule

// File: tb/tb_spi_regfile_target.sv
// Directed and randomized frames against a word-level regfile/SPI model.
module tb_spi_regfile_target;

   logic        axi_aclk = 1'b0;
   logic        axi_aresetn;
   logic        spi_sck, spi_csn, spi_mosi;
   logic        spi_miso, spi_miso_t;
   logic [3:0]  regfile_addr;
   logic [31:0] regfile_din, regfile_dout;
   logic        regfile_en;
   logic [3:0]  regfile_we;
   logic        busy, frame_err;

   int errors = 0;
   int checks = 0;
   int miso_t_bad = 0;

   always #5 axi_aclk = ~axi_aclk;

   spi_regfile_target #(.Naddr(4), .SYNC_STAGES(2)) dut (
      .axi_aclk     (axi_aclk),
      .axi_aresetn  (axi_aresetn),
      .spi_sck      (spi_sck),
      .spi_csn      (spi_csn),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .spi_miso_t   (spi_miso_t),
      .regfile_addr (regfile_addr),
      .regfile_din  (regfile_din),
      .regfile_dout (regfile_dout),
      .regfile_en   (regfile_en),
      .regfile_we   (regfile_we),
      .busy         (busy),
      .frame_err    (frame_err)
   );

   function automatic logic [31:0] preload(input int i);
      return (i == 0) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(i));
   endfunction

   // Regfile: 1-cycle read latency, byte write enables.
   logic [31:0] mem [16];
   bit          pre_done;
   always @(posedge axi_aclk) begin
      if (!pre_done) begin
         for (int i = 0; i < 16; i++) mem[i] <= preload(i);
         pre_done <= 1'b1;
      end else if (regfile_en === 1'b1) begin
         regfile_dout <= mem[regfile_addr];
         for (int b = 0; b < 4; b++)
            if (regfile_we[b]) mem[regfile_addr][8*b +: 8] <= regfile_din[8*b +: 8];
      end
   end

   logic [3:0]  log_addr [128];
   logic [3:0]  log_we   [128];
   logic [31:0] log_din  [128];
   int          acc_n;
   int          err_cycles;
   always @(posedge axi_aclk) begin
      if (regfile_en === 1'b1 && acc_n < 128) begin
         log_addr[acc_n] <= regfile_addr;
         log_we[acc_n]   <= regfile_we;
         log_din[acc_n]  <= regfile_din;
         acc_n           <= acc_n + 1;
      end
      if (frame_err === 1'b1) err_cycles <= err_cycles + 1;
   end

   logic [31:0] ref_mem [16];

   task automatic wait_clk(input int n);
      repeat (n) @(negedge axi_aclk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // SCK = clk/10; MISO is sampled just before each rising edge, as a controller would.
   task automatic spi_xfer(input logic [7:0] cmd, input logic [63:0] data, input int ndata,
                           input bit end_frame, output logic [63:0] rx);
      logic [71:0] bits;
      bits = {cmd, data};
      rx = '0;
      spi_csn = 1'b0;
      wait_clk(6);
      for (int i = 0; i < 8 + ndata; i++) begin
         spi_mosi = bits[71-i];
         wait_clk(5);
         if (i >= 8) rx = {rx[62:0], spi_miso};
         if (spi_miso_t !== 1'b0) miso_t_bad++;
         spi_sck = 1'b1;
         wait_clk(5);
         spi_sck = 1'b0;
      end
      spi_mosi = 1'b0;
      wait_clk(6);
      if (end_frame) begin
         spi_csn = 1'b1;
         wait_clk(8);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".en"},    64'(regfile_en),   64'd0);
      check({tag, ".we"},    64'(regfile_we),   64'd0);
      check({tag, ".addr"},  64'(regfile_addr), 64'd0);
      check({tag, ".din"},   64'(regfile_din),  64'd0);
      check({tag, ".busy"},  64'(busy),         64'd0);
      check({tag, ".err"},   64'(frame_err),    64'd0);
      check({tag, ".miso"},  64'(spi_miso),     64'd0);
      check({tag, ".misot"}, 64'(spi_miso_t),   64'd1);
   endtask

   // One complete single-word frame, judged against the word-level model.
   task automatic model_frame(input string tag, input logic [7:0] cmd, input logic [31:0] data);
      logic [63:0] rx;
      logic [3:0]  a;
      int          base, e0;
      a    = cmd[3:0];
      base = acc_n;
      e0   = err_cycles;
      miso_t_bad = 0;
      spi_xfer(cmd, {data, 32'h0}, 32, 1'b1, rx);
      check({tag, ".nacc"}, 64'(acc_n - base), 64'd1);
      check({tag, ".addr"}, 64'(log_addr[base]), 64'(a));
      check({tag, ".err"},  64'(err_cycles - e0), 64'd0);
      check({tag, ".misot_low"}, 64'(miso_t_bad), 64'd0);
      check({tag, ".misot_end"}, 64'(spi_miso_t), 64'd1);
      if (cmd[7]) begin
         check({tag, ".we"}, 64'(log_we[base]), 64'd0);
         check({tag, ".rx"}, 64'(rx[31:0]), 64'(ref_mem[a]));
      end else begin
         check({tag, ".we"},  64'(log_we[base]),  64'hf);
         check({tag, ".din"}, 64'(log_din[base]), 64'(data));
         ref_mem[a] = data;
      end
   endtask

   initial begin
      logic [63:0] rx;
      logic [31:0] w1, w2;
      int          base, e0;

      for (int i = 0; i < 16; i++) ref_mem[i] = preload(i);
      axi_aresetn = 1'b0;
      spi_sck     = 1'b0;
      spi_csn     = 1'b1;
      spi_mosi    = 1'b0;
      wait_clk(5);
      check_reset_outputs("reset");
      axi_aresetn = 1'b1;
      wait_clk(5);

      model_frame("wr03", 8'h03, 32'hA5A5_1234);
      model_frame("rd80", 8'h80, 32'h0);
      check("rd80.miso_idle", 64'(spi_miso), 64'd0);

      // Write aborted after 20 SCK cycles
      base = acc_n;
      e0   = err_cycles;
      spi_xfer(8'h01, {32'h1234_5678, 32'h0}, 12, 1'b0, rx);
      check("abort.busy_mid", 64'(busy), 64'd1);
      spi_csn = 1'b1;
      wait_clk(8);
      check("abort.busy_end", 64'(busy), 64'd0);
      check("abort.err", 64'(err_cycles - e0), 64'd1);
      check("abort.nacc", 64'(acc_n - base), 64'd0);
      model_frame("rd83", 8'h83, 32'h0);

      // CSn pulse with no SCK edges
      base = acc_n;
      e0   = err_cycles;
      spi_csn = 1'b0;
      wait_clk(10);
      spi_csn = 1'b1;
      wait_clk(10);
      check("empty.nacc", 64'(acc_n - base), 64'd0);
      check("empty.err",  64'(err_cycles - e0), 64'd0);

      model_frame("wr7f", 8'h7F, $urandom);
      model_frame("rdff", 8'hFF, 32'h0);

      // Reset asserted at bit 30 of a write
      base = acc_n;
      e0   = err_cycles;
      spi_xfer(8'h05, {32'h0BAD_F00D, 32'h0}, 22, 1'b0, rx);
      axi_aresetn = 1'b0;
      wait_clk(2);
      check_reset_outputs("rstmid");
      spi_csn = 1'b1;
      wait_clk(4);
      axi_aresetn = 1'b1;
      wait_clk(6);
      check("rstmid.nacc", 64'(acc_n - base), 64'd0);
      check("rstmid.err",  64'(err_cycles - e0), 64'd0);
      model_frame("wr05", 8'h05, 32'h5555_AAAA);
      model_frame("rd85", 8'h85, 32'h0);

      for (int n = 0; n < 6; n++)
         model_frame($sformatf("rnd%0d", n), 8'($urandom_range(0, 255)), $urandom);

      // Two-word write frame to address 15
      w1   = $urandom;
      w2   = $urandom;
      base = acc_n;
      e0   = err_cycles;
      spi_xfer(8'h0F, {w1, w2}, 64, 1'b1, rx);
      check("burst.err",   64'(err_cycles - e0), 64'd0);
      check("burst.addr0", 64'(log_addr[base]), 64'd15);
      check("burst.din0",  64'(log_din[base]),  64'(w1));
`ifdef SPI_TARGET_AUTO_INC_EN
      check("burst.nacc",  64'(acc_n - base), 64'd2);
      check("burst.addr1", 64'(log_addr[base+1]), 64'd0);
      check("burst.din1",  64'(log_din[base+1]),  64'(w2));
      ref_mem[0] = w2;
`else
      check("burst.nacc",  64'(acc_n - base), 64'd1);
`endif
      ref_mem[15] = w1;
      model_frame("rdf_after", 8'h8F, 32'h0);
      model_frame("rd0_after", 8'h80, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_regfile_target.md
Name: spi_regfile_target

Overview:
- SPI target (peripheral) that lets an external SPI controller read and write the register file.
- Counterpart to the PS-side SPI controller, for board-to-board links and for loopback from spi_1.
- Samples SCK/CSn/MOSI in the axi_aclk domain; SCK is oversampled, not used as a clock.
- Drives a single-port, BRAM-style regfile port with the same semantics as mem_regfile: `en`, `we[3:0]`, word address, 1-cycle read latency.

Parameters:
- Naddr, 4, regfile word-address width; 7-bit command address is truncated to its low Naddr bits.
- SYNC_STAGES, 2, synchronizer flops on spi_sck, spi_csn and spi_mosi (allowed range 2..3).

Ports:
- axi_aclk  input  1  sole clock; SPI SCK must be at most axi_aclk/10.
- axi_aresetn  input  1  asynchronous, active-low reset.
- spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_csn  input  1  chip select, active low.
- spi_mosi  input  1  controller-to-target data, MSB first.
- spi_miso  output  1  target-to-controller data.
- spi_miso_t  output  1  IOBUF tristate control; 1 = hi-Z.
- regfile_addr  output  Naddr  word address.
- regfile_din  output  32  write data.
- regfile_dout  input  32  read data, valid 1 cycle after regfile_en.
- regfile_en  output  1  access strobe, single cycle.
- regfile_we  output  4  byte write enables.
- busy  output  1  high while CSn is asserted (synchronized).
- frame_err  output  1  1-cycle pulse on a malformed frame.

Behaviour:
- Reset values:
  - spi_miso = 0, spi_miso_t = 1, regfile_en = 0, regfile_we = 0, regfile_addr = 0, regfile_din = 0, busy = 0, frame_err = 0.
  - FSM = IDLE, bit counter = 0.
  - Synchronizer flops reset to idle levels: sck = 0, csn = 1, mosi = 0.
- Edge detection: rising and falling SCK edges are detected on synchronized SCK (current vs previous sample).
- Frame format:
  - Byte 0 is the command: bit7 = 1 read / 0 write; bits 6:0 = word address.
  - Then 32 data bits, MSB first, 40 SCK cycles total.
- MOSI is sampled on the rising edge; MISO changes on the falling edge.
- spi_miso_t = 0 only while synchronized CSn is low, otherwise 1.
- FSM states:
  - IDLE: on the CSn falling edge, go to CMD, clear the bit counter, set busy = 1.
  - CMD: shift 8 bits.
    - On the 8th rising edge, latch the address.
    - Read: go to RD_FETCH.
    - Write: go to WR_DATA.
  - RD_FETCH: regfile_en = 1, we = 0 for exactly 1 cycle, then go to RD_LOAD.
  - RD_LOAD: capture regfile_dout into the shift register next cycle, then go to RD_DATA.
    - Total latency from the 8th rising-edge detect to shift-register load is 2 cycles; this must beat the following SCK falling edge, which the SCK ≤ axi_aclk/10 limit guarantees.
  - RD_DATA: on each falling edge, spi_miso = shift[31] and shift left. After 32 bits, go to DONE.
  - WR_DATA: shift MOSI in on rising edges.
    - On the 32nd bit: regfile_din = shift value, regfile_we = 4'hf, regfile_en = 1 for 1 cycle.
    - Then go to DONE.
  - DONE: further SCK edges are ignored; spi_miso = 0.
- Frame termination (CSn rising edge, checked from any state):
  - Return to IDLE; busy = 0, spi_miso = 0.
  - If the frame did not reach DONE (bit count not 0 and not complete), pulse frame_err.
  - A partial write never produces a regfile write.
  - A partial read has no side effects; the regfile read already issued is harmless.
- CSn low then high with zero SCK edges: no error, no access.
- A CSn falling edge while not in IDLE (glitch) is treated as a new frame: counter is cleared, no error is flagged.
- Reset mid-frame: all state is cleared immediately; any pending write is discarded.

Optional Feature:
- Macro: SPI_TARGET_AUTO_INC_EN (burst auto-increment).
- When defined:
  - After the first data word, the FSM does not enter DONE. The address increments, wrapping modulo 2**Naddr, and the next 32 bits form another word.
  - Write burst: one regfile write per complete word.
  - Read burst: the next-word fetch is issued on the rising edge of bit 32, so its data loads before the next falling edge.
  - A CSn rise on a word boundary is not an error; a CSn rise mid-word pulses frame_err.
- When undefined: single word per frame; bits after bit 40 are ignored, with MISO = 0 and no error.

Test Plan:
- Write cmd 0x03 + data 0xA5A5_1234 at SCK = clk/10 -> single pulse regfile_en = 1, we = 4'hf, addr = 3, din = 0xA5A5_1234; frame_err = 0.
- Read cmd 0x80, regfile_dout model returns 0xDEADBEEF -> MISO shifts 0xDEADBEEF MSB first; one en with we = 0, addr = 0; spi_miso_t = 0 only while CSn is low.
- Write frame aborted after 20 bits -> no regfile_en, frame_err pulses once, busy drops, FSM returns to IDLE; next full read frame works.
- Command address 0x7F with Naddr = 4 -> regfile_addr = 0xF.
- axi_aresetn asserted mid-write (bit 30) -> outputs return to reset values, no write; a fresh frame after release succeeds.
- With SPI_TARGET_AUTO_INC_EN: write cmd 0x0F + 2 words -> writes to addr 15 then 0; without the macro -> only addr 15 is written, no frame_err.
